// File: rtl/data_pipe_m2s_rr_arbiter_if.sv
// Selection bus between the round-robin arbiter (master) and the data-pipe interconnect (slave).
// Handshake: sw is qualified by vld_sw. The interconnect raises ready on path sw only while
// vld_sw=1. It reports each accepted transfer (valid&ready) as one beat, and marks the final
// beat of a packet with last.
interface data_pipe_m2s_rr_arbiter_if #(
  parameter int NUM   = 8,
  parameter int NSIZE = (NUM <= 2) ? 1 : (NUM <= 4) ? 2 : (NUM <= 8) ? 3 : (NUM <= 16) ? 4 : 5
);
  logic [NUM-1:0]   req;
  logic             beat;
  logic             last;
  logic [NSIZE-1:0] curr_path;
  logic             down_idle;
  logic [NSIZE-1:0] sw;
  logic             vld_sw;
  logic [NUM-1:0]   prio;

  modport master (
    input  req, beat, last, curr_path, down_idle,
    output sw, vld_sw, prio
  );

  modport slave (
    output req, beat, last, curr_path, down_idle,
    input  sw, vld_sw, prio
  );
endinterface

// File: rtl/data_pipe_m2s_rr_arbiter.sv
// Round-robin arbiter granting one of NUM slave paths to the data pipe, per packet, with a
// beat limit and an abandon timeout. state_dbg and rr_ptr_dbg expose internal state.
module data_pipe_m2s_rr_arbiter #(
  parameter int NUM       = 8,
  parameter int NSIZE     = (NUM <= 2) ? 1 : (NUM <= 4) ? 2 : (NUM <= 8) ? 3 : (NUM <= 16) ? 4 : 5,
  parameter int MAX_BEATS = 256
) (
  input  logic                      clock,
  input  logic                      rst_n,
  input  logic                      clk_en,
  data_pipe_m2s_rr_arbiter_if.master bus,
  output logic                      busy,
  output logic [15:0]               beat_cnt,
  output logic [1:0]                state_dbg,
  output logic [NSIZE-1:0]          rr_ptr_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWITCH = 2'd1,
    GRANT  = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [NSIZE-1:0] sw_q, sw_d;
  logic [NSIZE-1:0] rr_ptr_q, rr_ptr_d;
  logic [NSIZE-1:0] winner;
  logic [NSIZE-1:0] next_ptr;
  logic             win_found;
  logic [15:0]      beat_cnt_q, beat_cnt_d;
  logic [3:0]       tmo_q, tmo_d;
  logic             vld_q;
  logic [NUM-1:0]   prio_q, prio_d;
  logic             limit_hit;
  logic             req_sw;
  int               idx;

  // Scan upward from rr_ptr with wrap; the first requester found wins.
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM) idx = idx - NUM;
      if (!win_found && bus.req[NSIZE'(idx)]) begin
        win_found = 1'b1;
        winner    = NSIZE'(idx);
      end
    end
  end

  assign limit_hit = (MAX_BEATS != 0) && (({1'b0, beat_cnt_q} + 17'd1) == 17'(MAX_BEATS));
  assign req_sw    = bus.req[sw_q];
  assign next_ptr  = (sw_q == NSIZE'(NUM - 1)) ? '0 : sw_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    sw_d       = sw_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    tmo_d      = tmo_q;
    if (clk_en) begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_d    = SWITCH;
            sw_d       = winner;
            beat_cnt_d = '0;
          end
        end
        SWITCH: begin
          if (bus.curr_path == sw_q) begin
            state_d = GRANT;
            tmo_d   = '0;
          end
        end
        GRANT: begin
          if (bus.beat) begin
            tmo_d = '0;
            if (beat_cnt_q != 16'hFFFF) beat_cnt_d = beat_cnt_q + 16'd1;
            if (bus.last || limit_hit) state_d = DRAIN;
          end else if (!req_sw) begin
            // Sixteenth consecutive idle cycle with the request gone abandons the grant.
            if (tmo_q == 4'd15) state_d = DRAIN;
            else                tmo_d   = tmo_q + 4'd1;
          end else begin
            tmo_d = '0;
          end
          if (state_d == DRAIN) rr_ptr_d = next_ptr;
        end
        DRAIN: begin
          if (bus.down_idle) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    prio_d = '0;
    if (state_d == GRANT) prio_d[sw_d] = 1'b1;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sw_q       <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      tmo_q      <= '0;
      vld_q      <= 1'b0;
      prio_q     <= '0;
    end else begin
      state_q    <= state_d;
      sw_q       <= sw_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      tmo_q      <= tmo_d;
      vld_q      <= (state_d == GRANT);
      prio_q     <= prio_d;
    end
  end

  assign bus.sw     = sw_q;
  assign bus.vld_sw = vld_q;
  assign bus.prio   = prio_q;
  assign busy       = (state_q != IDLE);
  assign beat_cnt   = beat_cnt_q;
  assign state_dbg  = state_q;
  assign rr_ptr_dbg = rr_ptr_q;

endmodule
